// File: rtl/rr_burst_sched_if.sv
// Handshake bundle between the requesters, the burst scheduler and the downstream sink.
// Signal suffixes are from the scheduler's point of view.
interface rr_burst_sched_if #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32
);
  localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [NumIn-1:0]           req_i;
  logic [NumIn*DataWidth-1:0] data_i;
  logic [NumIn-1:0]           gnt_o;
  logic                       req_o;
  logic                       gnt_i;
  logic [DataWidth-1:0]       data_o;
  logic [IdxW-1:0]            idx_o;
  logic                       last_o;

  modport master (
    output req_i, data_i, gnt_i,
    input  gnt_o, req_o, data_o, idx_o, last_o
  );

  modport slave (
    input  req_i, data_i, gnt_i,
    output gnt_o, req_o, data_o, idx_o, last_o
  );
endinterface

// File: rtl/rr_burst_sched.sv
// Round-robin arbiter that locks onto one requester for up to MaxBurst beats,
// forwarding the owner's payload to a single downstream valid/accept port.
module rr_burst_sched #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  rr_burst_sched_if.slave bus
);
  localparam int IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int IdxW1 = IdxW + 1;
  localparam int CntW  = $clog2(MaxBurst + 1);

  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NumIn - 1);
  localparam logic [IdxW1-1:0] NumInW  = IdxW1'(NumIn);
  localparam logic [CntW-1:0]  CntLast = CntW'(MaxBurst - 1);

  typedef enum logic {
    Idle,
    Locked
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0]      scanSel;
  logic                 scanFound;
  logic [IdxW1-1:0]     cand;
  logic [IdxW-1:0]      sel;
  logic                 reqOut;
  logic                 lastOut;
  logic                 fire;
  logic [DataWidth-1:0] dataSel;

  function automatic logic [IdxW-1:0] nextPtr(input logic [IdxW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  // First active requester at or after the round-robin pointer, with wraparound.
  always_comb begin
    scanSel   = '0;
    scanFound = 1'b0;
    cand      = '0;
    for (int off = 0; off < NumIn; off++) begin
      cand = {1'b0, rr_q} + IdxW1'(off);
      if (cand >= NumInW) cand = cand - NumInW;
      if (!scanFound && bus.req_i[cand[IdxW-1:0]]) begin
        scanFound = 1'b1;
        scanSel   = cand[IdxW-1:0];
      end
    end
  end

  // Output side: gnt_i only reaches gnt_o, everything else depends on state and req_i.
  always_comb begin
    sel     = (state_q == Locked) ? owner_q : scanSel;
    reqOut  = (state_q == Locked) ? bus.req_i[owner_q] : (|bus.req_i);
    lastOut = reqOut & ((state_q == Locked) ? (cnt_q == CntLast) : (MaxBurst == 1));
    fire    = reqOut & bus.gnt_i;
    dataSel = '0;
    bus.gnt_o = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (sel == IdxW'(k)) begin
        dataSel      = bus.data_i[k*DataWidth +: DataWidth];
        bus.gnt_o[k] = fire;
      end
    end
    bus.req_o  = reqOut;
    bus.last_o = lastOut;
    bus.data_o = reqOut ? dataSel : '0;
    bus.idx_o  = reqOut ? sel : '0;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      Idle: begin
        if (fire) begin
          if (MaxBurst > 1) begin
            state_d = Locked;
            owner_d = sel;
            cnt_d   = CntW'(1);
          end else begin
            rr_d = nextPtr(sel);
          end
        end
      end
      Locked: begin
        // A dropped owner request ends the burst early; a stall simply holds.
        if (!bus.req_i[owner_q] || (fire && lastOut)) begin
          state_d = Idle;
          cnt_d   = '0;
          rr_d    = nextPtr(owner_q);
        end else if (fire) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= Idle;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rr_burst_sched.sv
// Directed bench for rr_burst_sched (NumIn=4, MaxBurst=2) with a per-cycle
// comparison against a behavioural round-robin burst model.
module tb_rr_burst_sched;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 2;

  logic clk;
  logic rst;
  logic flush;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  rr_burst_sched_if #(.NumIn(N), .DataWidth(DW)) bus ();

  rr_burst_sched #(.NumIn(N), .DataWidth(DW), .MaxBurst(MB)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: whether a burst is in progress, who owns it, beats taken, and where the scan starts.
  bit mLocked = 0, nLocked = 0;
  int mOwner = 0, nOwner = 0;
  int mBeats = 0, nBeats = 0;
  int mPtr = 0, nPtr = 0;

  int        eSel;
  bit        eFound;
  logic      eReq;
  logic      eLast;
  logic [3:0] eGnt;
  logic [1:0] eIdx;
  logic [31:0] eData;

  always @(negedge clk) begin
    eSel = 0;
    eFound = 0;
    if (mLocked) begin
      eSel = mOwner;
      eReq = bus.req_i[mOwner];
    end else begin
      for (int j = 0; j < N; j++) begin
        if (!eFound && bus.req_i[(mPtr + j) % N]) begin
          eSel = (mPtr + j) % N;
          eFound = 1;
        end
      end
      eReq = |bus.req_i;
    end
    eLast = eReq && (mLocked ? (mBeats == MB - 1) : (MB == 1));
    eGnt  = (eReq && bus.gnt_i) ? 4'(1 << eSel) : 4'b0000;
    eIdx  = eReq ? 2'(eSel) : 2'd0;
    eData = eReq ? bus.data_i[eSel*DW +: DW] : 32'd0;

    if (checkEn) begin
      checks++;
      if ({bus.idx_o, bus.gnt_o, bus.req_o, bus.last_o, bus.data_o} !==
          {eIdx, eGnt, eReq, eLast, eData}) begin
        errors++;
        $display("[TB] FAIL model_cycle t=%0t: got idx=%0d gnt=%b req=%b last=%b data=%h, expected idx=%0d gnt=%b req=%b last=%b data=%h",
                 $time, bus.idx_o, bus.gnt_o, bus.req_o, bus.last_o, bus.data_o,
                 eIdx, eGnt, eReq, eLast, eData);
      end
    end

    nLocked = mLocked;
    nOwner  = mOwner;
    nBeats  = mBeats;
    nPtr    = mPtr;
    if (rst || flush) begin
      nLocked = 0; nOwner = 0; nBeats = 0; nPtr = 0;
    end else if (mLocked) begin
      if (!eReq) begin
        nLocked = 0; nBeats = 0; nPtr = (mOwner + 1) % N;
      end else if (bus.gnt_i) begin
        nBeats = mBeats + 1;
        if (nBeats == MB) begin
          nLocked = 0; nBeats = 0; nPtr = (mOwner + 1) % N;
        end
      end
    end else if (eReq && bus.gnt_i) begin
      if (MB > 1) begin
        nLocked = 1; nOwner = eSel; nBeats = 1;
      end else begin
        nPtr = (eSel + 1) % N;
      end
    end
  end

  always @(posedge clk) begin
    mLocked <= nLocked;
    mOwner  <= nOwner;
    mBeats  <= nBeats;
    mPtr    <= nPtr;
  end

  task automatic applyStimulus(input logic r, input logic f, input logic [3:0] req, input logic g);
    @(posedge clk);
    #1;
    rst = r;
    flush = f;
    bus.req_i = req;
    bus.gnt_i = g;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [3:0] gnt,
                             input logic req, input logic last, input logic [31:0] data);
    #1;
    checks++;
    if ({bus.idx_o, bus.gnt_o, bus.req_o, bus.last_o, bus.data_o} !==
        {2'(idx), gnt, req, last, data}) begin
      errors++;
      $display("[TB] FAIL %s: got idx=%0d gnt=%b req=%b last=%b data=%h, expected idx=%0d gnt=%b req=%b last=%b data=%h",
               name, bus.idx_o, bus.gnt_o, bus.req_o, bus.last_o, bus.data_o,
               idx, gnt, req, last, data);
    end
  endtask

  task automatic checkModelPtr(input string name, input int expPtr);
    checks++;
    if (mPtr != expPtr) begin
      errors++;
      $display("[TB] FAIL %s: model pointer got %0d, expected %0d", name, mPtr, expPtr);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.req_i = '0;
    bus.gnt_i = 1'b0;
    for (int k = 0; k < N; k++) bus.data_i[k*DW +: DW] = 32'hA0 + 32'(k);

    applyStimulus(1, 0, 4'b0000, 0);
    applyStimulus(1, 0, 4'b0000, 0);
    checkEn = 1;
    applyStimulus(0, 0, 4'b0000, 0);
    checkOutput("reset_idle", 0, 4'b0000, 0, 0, 32'h0);

    // Two requesters alternate in two-beat bursts.
    applyStimulus(0, 0, 4'b1010, 1);
    checkOutput("rr_first_beat", 1, 4'b0010, 1, 0, 32'hA1);
    applyStimulus(0, 0, 4'b1010, 1);
    checkOutput("rr_second_beat", 1, 4'b0010, 1, 1, 32'hA1);
    applyStimulus(0, 0, 4'b1010, 1);
    checkOutput("rr_next_owner", 3, 4'b1000, 1, 0, 32'hA3);
    applyStimulus(0, 0, 4'b1010, 1);
    checkOutput("rr_next_owner_last", 3, 4'b1000, 1, 1, 32'hA3);
    applyStimulus(0, 0, 4'b1010, 1);
    checkOutput("rr_back_to_one", 1, 4'b0010, 1, 0, 32'hA1);

    // Downstream stall while locked on requester 1.
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 0, 4'b1111, 0);
      checkOutput("lock_stall", 1, 4'b0000, 1, 1, 32'hA1);
    end
    applyStimulus(0, 0, 4'b1111, 1);
    checkOutput("lock_release", 1, 4'b0010, 1, 1, 32'hA1);
    applyStimulus(0, 0, 4'b1111, 1);
    checkModelPtr("ptr_after_release", 2);
    checkOutput("after_release", 2, 4'b0100, 1, 0, 32'hA2);

    // Owner 2 drops its request mid-burst.
    applyStimulus(0, 0, 4'b1011, 1);
    checkOutput("owner_drop", 0, 4'b0000, 0, 0, 32'h0);
    applyStimulus(0, 0, 4'b0001, 1);
    checkModelPtr("ptr_after_drop", 3);
    checkOutput("after_drop", 0, 4'b0001, 1, 0, 32'hA0);
    applyStimulus(0, 0, 4'b0001, 1);
    checkOutput("owner0_last", 0, 4'b0001, 1, 1, 32'hA0);

    // Owner 3 completes a burst and the pointer wraps to 0.
    applyStimulus(0, 0, 4'b1000, 1);
    checkOutput("owner3_first", 3, 4'b1000, 1, 0, 32'hA3);
    applyStimulus(0, 0, 4'b1111, 1);
    checkOutput("owner3_last", 3, 4'b1000, 1, 1, 32'hA3);
    applyStimulus(0, 0, 4'b1111, 1);
    checkModelPtr("ptr_wrap", 0);
    checkOutput("wrap_grant", 0, 4'b0001, 1, 0, 32'hA0);
    applyStimulus(0, 0, 4'b1111, 1);
    checkOutput("wrap_owner_last", 0, 4'b0001, 1, 1, 32'hA0);

    // Flush in the middle of owner 2's burst.
    applyStimulus(0, 0, 4'b0100, 1);
    checkOutput("flush_setup", 2, 4'b0100, 1, 0, 32'hA2);
    applyStimulus(0, 1, 4'b0100, 0);
    checkOutput("flush_cycle", 2, 4'b0000, 1, 1, 32'hA2);
    applyStimulus(0, 0, 4'b0110, 0);
    checkOutput("after_flush", 1, 4'b0000, 1, 0, 32'hA1);

    // Reset together with flush gives the same result.
    applyStimulus(0, 0, 4'b0100, 1);
    checkOutput("rstflush_setup", 2, 4'b0100, 1, 0, 32'hA2);
    applyStimulus(1, 1, 4'b0100, 0);
    applyStimulus(0, 0, 4'b0110, 0);
    checkOutput("after_rst_flush", 1, 4'b0000, 1, 0, 32'hA1);

    // Flush while idle and transferring discards the would-be lock.
    applyStimulus(0, 1, 4'b1000, 1);
    checkOutput("flush_idle_xfer", 3, 4'b1000, 1, 0, 32'hA3);
    applyStimulus(0, 0, 4'b0110, 1);
    checkOutput("after_idle_flush", 1, 4'b0010, 1, 0, 32'hA1);

    applyStimulus(0, 0, 4'b0000, 0);
    applyStimulus(0, 0, 4'b0000, 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
